// File: rtl/vld_rdy_pkg.sv
// Shared types and constants for the valid-ready traffic source.
// States, data modes and default LFSR taps/seeds.
package vld_rdy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic MODE_INC  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  localparam logic [23:0] DEF_TAP_MASK = 24'hE10000;
  localparam logic [15:0] DEF_GAP_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11, maximal length
  localparam logic [15:0] DEF_GAP_TAPS = 16'hB400;

endpackage

// File: rtl/vld_rdy_lfsr.sv
// Generic shift-left LFSR register with parallel load.
// Feedback bit is the parity of the tapped state bits.
import vld_rdy_pkg::*;

module vld_rdy_lfsr #(
  parameter int         W    = 16,
  parameter logic [W-1:0] TAPS = '0,
  parameter logic [W-1:0] SEED = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = {q_q[W-2:0], ^(q_q & TAPS)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/vld_rdy_source.sv
// Valid-ready frame transmitter: incrementing or LFSR payload.
// Define VLD_RDY_SOURCE_GAP_EN for pseudo-random one-cycle gaps.
import vld_rdy_pkg::*;

module vld_rdy_source #(
  parameter int                    DATA_WIDTH = 24,
  parameter int                    LEN_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] TAP_MASK   = DEF_TAP_MASK,
  parameter logic [15:0]           GAP_SEED   = DEF_GAP_SEED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_init,
  output logic                  valid,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beat_cnt
);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_q, beat_d;
  logic                 mode_q, mode_d;
  logic                 done_q, done_d;

  logic                  cap;
  logic                  xfer;
  logic                  last;
  logic                  gap_hit;
  logic [DATA_WIDTH-1:0] init_v;
  logic [DATA_WIDTH-1:0] ld_val;

  assign valid    = (state_q == ST_SEND);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign beat_cnt = beat_q;

  assign cap  = (state_q == ST_IDLE) && start && (cfg_len != '0);
  assign xfer = valid && ready;
  assign last = (beat_q == len_q - LEN_WIDTH'(1));

  // all-zero LFSR state would lock up
  assign init_v = (cfg_mode == MODE_LFSR && cfg_init == '0)
                ? DATA_WIDTH'(1) : cfg_init;
  assign ld_val = cap ? init_v : data + DATA_WIDTH'(1);

  vld_rdy_lfsr #(
    .W    (DATA_WIDTH),
    .TAPS (TAP_MASK),
    .SEED ('0)
  ) u_data (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (xfer && mode_q == MODE_LFSR),
    .load_i     (cap || (xfer && mode_q == MODE_INC)),
    .load_val_i (ld_val),
    .q_o        (data)
  );

`ifdef VLD_RDY_SOURCE_GAP_EN
  logic [15:0] gap_q;

  vld_rdy_lfsr #(
    .W    (16),
    .TAPS (DEF_GAP_TAPS),
    .SEED (GAP_SEED)
  ) u_gap (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (busy),
    .load_i     (1'b0),
    .load_val_i (16'h0000),
    .q_o        (gap_q)
  );

  assign gap_hit = gap_q[0];
`else
  assign gap_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    mode_d  = mode_q;
    beat_d  = beat_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_SEND;
            len_d   = cfg_len;
            mode_d  = cfg_mode;
            beat_d  = '0;
          end
        end
      end
      ST_SEND: begin
        if (xfer) begin
          beat_d = beat_q + LEN_WIDTH'(1);
          if (last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (gap_hit) begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        state_d = ST_SEND;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      mode_q  <= MODE_INC;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_vld_rdy_source.sv
// Scoreboard bench for vld_rdy_source: expected beats queued by
// stimulus, popped by a monitor on each observed transfer.
module tb_vld_rdy_source;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_len;
  logic        cfg_mode;
  logic [23:0] cfg_init;
  logic        valid;
  logic        ready;
  logic [23:0] data;
  logic        busy;
  logic        done;
  logic [15:0] beat_cnt;

  int nvec = 0;
  int nerr = 0;
  int gap_cnt = 0;

  logic [23:0] exp_q[$];

  logic        hold_prev = 1'b0;
  logic [23:0] hold_data = '0;
  logic        xfer_prev = 1'b0;

  vld_rdy_source dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_len  (cfg_len),
    .cfg_mode (cfg_mode),
    .cfg_init (cfg_init),
    .valid    (valid),
    .ready    (ready),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .beat_cnt (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: scoreboard, hold-stability and gap legality
  always @(negedge clk) begin
    if (rst_n) begin
      if ($isunknown({valid, ready, busy, done})) begin
        chk("no_x", 32'(1), 32'(0));
      end
      if (hold_prev) begin
        chk("hold_valid", 32'(valid), 32'(1));
        chk("hold_data", 32'(data), 32'(hold_data));
      end
      if (busy && !valid) begin
        gap_cnt++;
        chk("gap_after_xfer", 32'(xfer_prev), 32'(1));
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(data), 32'hFFFF_FFFF);
        end else begin
          chk("beat_data", 32'(data), 32'(exp_q.pop_front()));
        end
      end
      hold_prev = valid && !ready;
      hold_data = data;
      xfer_prev = valid && ready;
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    if (!done) chk("done_timeout", 32'(n), 32'(0));
  endtask

  task automatic frame(input logic [15:0] len,
                       input logic mode,
                       input logic [23:0] init,
                       output int n);
    cfg_len  = len;
    cfg_mode = mode;
    cfg_init = init;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    ready    = 1'b1;
    cfg_len  = '0;
    cfg_mode = 1'b0;
    cfg_init = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_data", 32'(data), 32'(0));
    chk("rst_beat", 32'(beat_cnt), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // back-to-back incrementing
    exp_q.push_back(24'h000010);
    exp_q.push_back(24'h000011);
    exp_q.push_back(24'h000012);
    exp_q.push_back(24'h000013);
    frame(16'd4, 1'b0, 24'h000010, n);
    chk("b2b_cycles", 32'(n), 32'(5));
    chk("b2b_beat", 32'(beat_cnt), 32'(4));
    chk("b2b_busy", 32'(busy), 32'(0));
    chk("b2b_valid", 32'(valid), 32'(0));

    // restart accepted in the done cycle: wrap
    exp_q.push_back(24'hFFFFFF);
    exp_q.push_back(24'h000000);
    frame(16'd2, 1'b0, 24'hFFFFFF, n);
    chk("wrap_cycles", 32'(n), 32'(3));
    chk("wrap_beat", 32'(beat_cnt), 32'(2));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'(0));

    // backpressure
    ready    = 1'b0;
    cfg_len  = 16'd3;
    cfg_mode = 1'b0;
    cfg_init = 24'h000100;
    exp_q.push_back(24'h000100);
    exp_q.push_back(24'h000101);
    exp_q.push_back(24'h000102);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(valid), 32'(1));
      chk("bp_data", 32'(data), 32'h000100);
      chk("bp_beat", 32'(beat_cnt), 32'(0));
    end
    ready = 1'b1;
    wait_done(n);
    chk("bp_cycles", 32'(n), 32'(3));
    chk("bp_beat_end", 32'(beat_cnt), 32'(3));
    @(negedge clk);

    // zero length
    cfg_len  = 16'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("zero_done", 32'(done), 32'(1));
    chk("zero_valid", 32'(valid), 32'(0));
    @(negedge clk);
    chk("zero_done_off", 32'(done), 32'(0));
    chk("zero_valid2", 32'(valid), 32'(0));
    chk("zero_busy", 32'(busy), 32'(0));

    // LFSR mode, zero seed replaced by 1
    exp_q.push_back(24'h000001);
    exp_q.push_back(24'h000002);
    exp_q.push_back(24'h000004);
    frame(16'd3, 1'b1, 24'h000000, n);
    chk("lfsr0_cycles", 32'(n), 32'(4));

    // LFSR mode with feedback taps hit
    exp_q.push_back(24'h400000);
    exp_q.push_back(24'h800001);
    exp_q.push_back(24'h000003);
    frame(16'd3, 1'b1, 24'h400000, n);
    chk("lfsr1_cycles", 32'(n), 32'(4));

    // async reset mid-frame
    cfg_len  = 16'd8;
    cfg_mode = 1'b0;
    cfg_init = 24'h000020;
    exp_q.push_back(24'h000020);
    exp_q.push_back(24'h000021);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_data", 32'(data), 32'(0));
    chk("arst_beat", 32'(beat_cnt), 32'(0));
    repeat (2) begin
      @(negedge clk);
      chk("arst_no_done", 32'(done), 32'(0));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_done", 32'(done), 32'(0));
    exp_q.push_back(24'h000020);
    exp_q.push_back(24'h000021);
    frame(16'd2, 1'b0, 24'h000020, n);
    chk("arst_restart", 32'(n), 32'(3));

`ifdef VLD_RDY_SOURCE_GAP_EN
    gap_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(24'(i));
    end
    frame(16'd16, 1'b0, 24'h000000, n);
    chk("gap_cycles", 32'(n), 32'(17 + gap_cnt));
    chk("gap_beat", 32'(beat_cnt), 32'(16));
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/vld_rdy_source.md
Name: vld_rdy_source

Overview:
- Synthesizable valid-ready transmitter. Drives frames of data beats onto a valid-ready channel, starting on a `start` command.
- Strictly honours the channel rules on its output:
  - valid never drops before a transfer;
  - data is held stable while valid=1 and ready=0;
  - valid and ready are never X after reset.
- Used as on-chip traffic source / BIST stimulus for pixel-stream consumers. Its output is legal to monitor with the team's protocol checker.

Parameters:
- DATA_WIDTH, 24, width of the data bus.
- LEN_WIDTH, 16, width of the frame-length configuration and beat counter.
- TAP_MASK, 24'hE10000, feedback taps for LFSR data mode (bit i set = data[i] in the XOR).
- GAP_SEED, 16'hACE1, reset seed of the gap LFSR (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  frame request; sampled only in IDLE.
- cfg_len  input  LEN_WIDTH  beats per frame; captured on accepted start.
- cfg_mode  input  1  0 = incrementing data, 1 = LFSR data; captured on start.
- cfg_init  input  DATA_WIDTH  first data value; captured on start.
- valid  output  1  data valid.
- ready  input  1  sink ready.
- data  output  DATA_WIDTH  beat payload.
- busy  output  1  high from the cycle after an accepted start until the final transfer completes.
- done  output  1  one-cycle pulse at end of frame.
- beat_cnt  output  LEN_WIDTH  beats transferred in the current or last frame.

Behaviour:
- Reset (async, rst_n=0): all outputs are zero (valid, data, busy, done, beat_cnt) and the state machine is IDLE. Effect is immediate, including mid-frame; the aborted frame produces no done pulse.
- States: IDLE, SEND, GAP. GAP exists only with the optional feature.
- IDLE:
  - start=1 and cfg_len!=0:
    - next edge: capture cfg_len, cfg_mode and data=cfg_init; beat_cnt=0; valid=1; busy=1; go SEND.
    - Latency from start to valid = 1 cycle.
  - start=1 and cfg_len==0: done=1 for one cycle; stay IDLE; valid stays 0.
- SEND:
  - Transfer = valid & ready at a rising edge. No transfer: valid, data and beat_cnt hold.
  - On transfer:
    - beat_cnt increments.
    - data advances. Incrementing mode: data+1, wrapping all-ones -> 0. LFSR mode: data = {data[W-2:0], ^(data & TAP_MASK)}.
    - LFSR mode: a captured cfg_init of 0 is replaced by 1 at capture, avoiding lock-up.
  - Final transfer (beat_cnt == len-1): next edge valid=0, busy=0, done=1 (one cycle), go IDLE. beat_cnt keeps the final value (= len) until the next accepted start.
  - Non-final transfer with ready held high: valid stays 1, giving one beat per cycle with no bubbles.
- start while busy: ignored, no effect.
- ready while valid=0: ignored.
- Throughput: len beats complete in len cycles when ready is constantly 1; done follows 1 cycle after the last transfer.
- A new start is accepted in the cycle done is high; valid returns 1 cycle later.

Optional Feature:
- Macro: VLD_RDY_SOURCE_GAP_EN.
- Defined:
  - A 16-bit gap LFSR, seeded with GAP_SEED at reset, advances every clock while busy.
  - After each non-final transfer, if gap LFSR bit0 = 1, the FSM enters GAP: valid=0 for exactly one cycle, data already advanced, then back to SEND with valid=1.
  - This is legal because valid drops only after a completed transfer.
  - GAP is never entered after the final transfer.
- Not defined: GAP state and gap LFSR are absent; beats are issued back-to-back whenever ready=1.

Decomposition:
- Shared package vld_rdy_pkg:
  - state encoding (IDLE, SEND, GAP);
  - mode constants MODE_INC=0, MODE_LFSR=1;
  - default TAP_MASK and GAP_SEED constants.
- One sub-module: vld_rdy_lfsr.
  - Generic width/taps/seed; enable and load inputs.
  - Instantiated for gap generation; its next-state function is reused for data advance.

Test Plan:
- Back-to-back: cfg_len=4, cfg_mode=0, cfg_init=24'h000010, ready=1 constant -> data 10,11,12,13 on 4 consecutive cycles; done pulse on the next cycle; beat_cnt=4.
- Backpressure: cfg_len=3, ready low for 5 cycles after valid rises -> valid and data=cfg_init held constant all 5 cycles; no X; protocol checker silent.
- Wrap and zero-length:
  - cfg_init=24'hFFFFFF, cfg_len=2 -> data FFFFFF then 000000.
  - start with cfg_len=0 -> single done pulse, valid never rises.
- LFSR mode: cfg_mode=1, cfg_init=0, cfg_len=3 -> first beat data=1, next beats match the reference model of TAP_MASK shift.
- Reset mid-frame: rst_n low asynchronously during beat 2 of 8 -> valid and busy drop without a clock edge; no done pulse; next start restarts at cfg_init.
- Gap (macro defined): cfg_len=16, ready=1 -> every valid low cycle directly follows a transfer; total cycles = 16 + gap count; data sequence unbroken.
